// File: rtl/frame_pattern_gen_if.sv
// Purpose: groups the pattern generator's control inputs and frame outputs into one bundle.
// Latency: none; this is wiring only.
// Backpressure: none; Cycle from the send stage paces the frames.
// Ports: Go/Cycle/Mode/BaseColor are driven by the master; GRBSeq/Position/Running are driven by the slave (the generator).
interface frame_pattern_gen_if;
  logic         Go;
  logic         Cycle;
  logic [1:0]   Mode;
  logic [23:0]  BaseColor;
  logic [119:0] GRBSeq;
  logic [2:0]   Position;
  logic         Running;

  modport master (
    output Go, Cycle, Mode, BaseColor,
    input  GRBSeq, Position, Running
  );

  modport slave (
    input  Go, Cycle, Mode, BaseColor,
    output GRBSeq, Position, Running
  );
endinterface

// File: rtl/frame_pattern_gen.sv
// Purpose: 5-LED GRB frame generator (off / solid / scanner / chase) stepped by frame-done strobes.
// Latency: GRBSeq updates one clk after RUN entry or after the Cycle edge that steps the pattern.
// Backpressure: none; the pattern holds between Cycle edges, so a frame never changes mid-send.
// Ports: clk, reset (sync, active-high); bus (slave): Go, Cycle, Mode, BaseColor in; GRBSeq, Position, Running out.
module frame_pattern_gen #(
  parameter logic [7:0] FRAMES_PER_STEP = 8'd4,
  parameter int         NUM_LEDS        = 5
) (
  input  logic          clk,
  input  logic          reset,
  frame_pattern_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SOLID = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;
  localparam logic [1:0] MODE_CHASE = 2'b11;

  state_t       state_q, state_d;
  logic         cycle_q;
  logic         cyc_ev;
  logic [7:0]   cnt_q;
  logic         dir_up_q;
  logic [2:0]   pos_q;
  logic [1:0]   mode_l;
  logic [23:0]  color_l;
  logic [119:0] grb_q;

  logic [23:0]  half;
  logic [2:0]   pos_up, pos_dn, chase_prev;
  logic [2:0]   next_pos;
  logic         next_dir_up;
  logic [23:0]  led;
  logic [119:0] pat;

  // A held-high Cycle counts once: only the rising edge is an event.
  assign cyc_ev = bus.Cycle & ~cycle_q;

  assign half = {1'b0, color_l[23:17], 1'b0, color_l[15:9], 1'b0, color_l[7:1]};

  // Out-of-range neighbours (pos+1 = 5, pos-1 wrapping to 7) never match an
  // LED index, so scanner trails clip at the strip ends without extra checks.
  assign pos_up     = pos_q + 3'd1;
  assign pos_dn     = pos_q - 3'd1;
  assign chase_prev = (pos_q == 3'd0) ? 3'd4 : pos_dn;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; Go is ignored in BLANK so the strip finishes a blank frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.Go) state_d = RUN;
      RUN:     if (!bus.Go) state_d = BLANK;
      BLANK:   if (cyc_ev) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next position on a step. Off and solid modes walk like the scanner; the
  // position is not visible in their frames.
  always_comb begin
    next_pos    = pos_q;
    next_dir_up = dir_up_q;
    if (mode_l == MODE_CHASE) begin
      next_pos = (pos_q == 3'd4) ? 3'd0 : pos_up;
    end else if (dir_up_q) begin
      if (pos_q == 3'd4) begin
        next_pos    = 3'd3;
        next_dir_up = 1'b0;
      end else begin
        next_pos = pos_up;
      end
    end else begin
      if (pos_q == 3'd0) begin
        next_pos    = 3'd1;
        next_dir_up = 1'b1;
      end else begin
        next_pos = pos_dn;
      end
    end
  end

  // Frame pattern from the latched mode/colour; LED0 sits in the top 24 bits.
  always_comb begin
    pat = '0;
    led = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      led = '0;
      case (mode_l)
        MODE_SOLID: led = color_l;
        MODE_SCAN: begin
          if (3'(i) == pos_q)                          led = color_l;
          else if (3'(i) == pos_up || 3'(i) == pos_dn) led = half;
        end
        MODE_CHASE: begin
          if (3'(i) == pos_q)           led = color_l;
          else if (3'(i) == chase_prev) led = half;
        end
        default: led = '0;
      endcase
      pat[(NUM_LEDS-1-i)*24 +: 24] = led;
    end
  end

  // Datapath. A Cycle edge in the clk Go falls is not a step: the RUN branch
  // below requires Go, and the FSM leaves RUN on that same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q  <= 1'b0;
      cnt_q    <= '0;
      dir_up_q <= 1'b1;
      pos_q    <= '0;
      mode_l   <= '0;
      color_l  <= '0;
      grb_q    <= '0;
    end else begin
      cycle_q <= bus.Cycle;
      grb_q   <= (state_q == RUN) ? pat : '0;
      if (state_q == IDLE && bus.Go) begin
        pos_q    <= '0;
        dir_up_q <= 1'b1;
        cnt_q    <= '0;
        mode_l   <= bus.Mode;
        color_l  <= bus.BaseColor;
      end else if (state_q == RUN && bus.Go && cyc_ev) begin
        if (cnt_q == FRAMES_PER_STEP - 8'd1) begin
          cnt_q    <= '0;
          pos_q    <= next_pos;
          dir_up_q <= next_dir_up;
          mode_l   <= bus.Mode;
          color_l  <= bus.BaseColor;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

  assign bus.GRBSeq   = grb_q;
  assign bus.Position = pos_q;
  assign bus.Running  = (state_q == RUN);

endmodule

// File: tb/tb_frame_pattern_gen.sv
module tb_frame_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  frame_pattern_gen_if ia ();
  frame_pattern_gen_if ib ();

  // dut_a steps on every Cycle edge; dut_b uses the default of 4.
  frame_pattern_gen #(.FRAMES_PER_STEP(8'd1), .NUM_LEDS(5)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ia.slave));
  frame_pattern_gen dut_b (
    .clk(clk), .reset(rst_b), .bus(ib.slave));

  typedef struct {
    bit           sel;
    logic [2:0]   pos;
    bit           run;
    bit           cg;
    logic [119:0] grb;
    int           at;
  } exp_t;

  exp_t  q[$];
  string qn[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [119:0] SOLID = {5{24'h102030}};
  localparam logic [119:0] S0 = 120'hFF8040_7F4020_000000_000000_000000;
  localparam logic [119:0] S2 = 120'h000000_7F4020_FF8040_7F4020_000000;
  localparam logic [119:0] S4 = 120'h000000_000000_000000_7F4020_FF8040;
  localparam logic [119:0] C0 = 120'hFF8040_000000_000000_000000_7F4020;
  localparam logic [119:0] C1 = 120'h7F4020_FF8040_000000_000000_000000;
  localparam logic [119:0] N2 = 120'h000000_010203_020406_000000_000000;
  localparam logic [119:0] N0 = 120'h020406_000000_000000_000000_010203;
  localparam logic [119:0] B0 = 120'h102030_081018_000000_000000_000000;
  localparam logic [119:0] B1 = 120'h081018_102030_081018_000000_000000;

  int scan_seq[10]  = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
  int chase_seq[6]  = '{1, 2, 3, 4, 0, 1};
  int hold_seq[8]   = '{0, 0, 0, 1, 1, 1, 1, 2};

  // Monitor: pops every expectation whose sample point has come and compares.
  exp_t         me;
  string        mn;
  logic [2:0]   ap;
  logic         ar;
  logic [119:0] ag;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      me = q.pop_front();
      mn = qn.pop_front();
      ap = me.sel ? ib.Position : ia.Position;
      ar = me.sel ? ib.Running  : ia.Running;
      ag = me.sel ? ib.GRBSeq   : ia.GRBSeq;
      checks++;
      if (ap !== me.pos || ar !== me.run || (me.cg && ag !== me.grb)) begin
        errors++;
        $display("FAIL %s: got pos=%0d run=%0b grb=%h, want pos=%0d run=%0b grb=%h%s",
                 mn, ap, ar, ag, me.pos, me.run, me.grb, me.cg ? "" : " (grb not checked)");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input bit sel, input string nm, input int p, input bit r,
                            input bit cg, input logic [119:0] g);
    exp_t e;
    e.sel = sel;
    e.pos = 3'(p);
    e.run = r;
    e.cg  = cg;
    e.grb = g;
    e.at  = cyc;
    q.push_back(e);
    qn.push_back(nm);
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    ia.Go = 1'b0;
    ia.Cycle = 1'b0;
    tick();
    rst_a = 1'b0;
  endtask

  task automatic pulse_a();
    ia.Cycle = 1'b1;
    tick();
    ia.Cycle = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [119:0] g;
    bit cg;

    rst_a = 1'b1; rst_b = 1'b1;
    ia.Go = 1'b0; ia.Cycle = 1'b0; ia.Mode = 2'b00; ia.BaseColor = '0;
    ib.Go = 1'b0; ib.Cycle = 1'b0; ib.Mode = 2'b00; ib.BaseColor = '0;
    tick();
    tick();
    expect_now(0, "reset_a", 0, 0, 1, '0);
    expect_now(1, "reset_b", 0, 0, 1, '0);

    // Solid mode: Running after one clk, frame after two.
    rst_a = 1'b0;
    ia.Go = 1'b1; ia.Mode = 2'b01; ia.BaseColor = 24'h102030;
    tick();
    expect_now(0, "solid_clk1", 0, 1, 1, '0);
    tick();
    expect_now(0, "solid_clk2", 0, 1, 1, SOLID);

    // Scanner bounce, one step per Cycle pulse.
    reset_a();
    ia.Mode = 2'b10; ia.BaseColor = 24'hFF8040; ia.Go = 1'b1;
    tick();
    tick();
    expect_now(0, "scan_entry", 0, 1, 1, S0);
    for (int k = 0; k < 10; k++) begin
      pulse_a();
      cg = 1'b1;
      case (k)
        1, 9:    g = S2;
        3:       g = S4;
        7:       g = S0;
        default: begin g = '0; cg = 1'b0; end
      endcase
      expect_now(0, $sformatf("scan%0d", k), scan_seq[k], 1, cg, g);
    end

    // Chase with wrap trail.
    reset_a();
    ia.Mode = 2'b11; ia.BaseColor = 24'hFF8040; ia.Go = 1'b1;
    tick();
    tick();
    expect_now(0, "chase_entry", 0, 1, 1, C0);
    for (int k = 0; k < 6; k++) begin
      pulse_a();
      cg = 1'b1;
      case (k)
        3:       g = S4;
        4:       g = C0;
        5:       g = C1;
        default: begin g = '0; cg = 1'b0; end
      endcase
      expect_now(0, $sformatf("chase%0d", k), chase_seq[k], 1, cg, g);
    end

    // New colour only takes effect at the next step.
    ia.BaseColor = 24'h020406;
    tick();
    expect_now(0, "color_hold", 1, 1, 1, C1);
    pulse_a();
    expect_now(0, "color_step", 2, 1, 1, N2);

    // Go falls with a Cycle edge: no step, blank, Go ignored until next edge.
    ia.Go = 1'b0; ia.Cycle = 1'b1;
    tick();
    expect_now(0, "go_drop_nostep", 2, 0, 1, N2);
    ia.Cycle = 1'b0; ia.Go = 1'b1;
    tick();
    expect_now(0, "blank_zero", 2, 0, 1, '0);
    tick();
    expect_now(0, "blank_ignores_go", 2, 0, 1, '0);
    ia.Cycle = 1'b1;
    tick();
    expect_now(0, "blank_to_idle", 2, 0, 1, '0);
    ia.Cycle = 1'b0;
    tick();
    expect_now(0, "idle_to_run", 0, 1, 1, '0);
    tick();
    expect_now(0, "rerun_frame", 0, 1, 1, N0);

    // Reset mid-RUN at position 3 with Go still high.
    pulse_a();
    pulse_a();
    pulse_a();
    expect_now(0, "pre_reset_pos3", 3, 1, 0, '0);
    rst_a = 1'b1;
    tick();
    expect_now(0, "mid_run_reset", 0, 0, 1, '0);
    rst_a = 1'b0;
    tick();
    expect_now(0, "reset_rerun", 0, 1, 1, '0);
    tick();
    expect_now(0, "reset_rerun_frame", 0, 1, 1, N0);

    // Default FRAMES_PER_STEP=4, Cycle held high 5 clks per pulse.
    rst_b = 1'b0;
    ib.Mode = 2'b10; ib.BaseColor = 24'h102030; ib.Go = 1'b1;
    tick();
    tick();
    expect_now(1, "hold_entry", 0, 1, 1, B0);
    for (int p = 0; p < 8; p++) begin
      ib.Cycle = 1'b1;
      repeat (5) tick();
      ib.Cycle = 1'b0;
      repeat (2) tick();
      expect_now(1, $sformatf("hold%0d", p), hold_seq[p], 1, (p == 3), B1);
    end

    tick();
    tick();
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations never sampled, required 0", q.size());
      errors += q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
